// File: rtl/vga_timing_ctrl.sv
`timescale 1ns/1ps
// vga_timing_ctrl: pixel/line counters, sync/blank decode and frame strobes
// for 640x480@60 VGA. Horizontal and vertical phases are tracked by small
// FSMs stepped from the same tick/line-wrap edges that move the counters, so
// phase and counter range always agree.
// Every output is decoded from registered state. pix_tick, line_end and
// frame_end are one-clk strobes that need no handshake: they are valid in the
// cycle they are high, and no ready or back-pressure exists on this block.
module vga_timing_ctrl #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int CLK_DIV  = 1,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       enable,
    output logic       pix_tick,
    output logic [9:0] pix_x,
    output logic [9:0] pix_y,
    output logic       hsync,
    output logic       vsync,
    output logic       active,
    output logic       line_end,
    output logic       frame_end,
    output logic [7:0] frame_count
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Counters are 10 bits wide; larger totals cannot be represented.
    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_total_overflow
        $error("vga_timing_ctrl: H_TOTAL/V_TOTAL exceed 10-bit counter range");
    end
    if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_clk_div_range
        $error("vga_timing_ctrl: CLK_DIV must be in 1..16");
    end

    // Last count of each phase; a phase ends on the tick at its last count.
    localparam logic [9:0] H_ACT_LAST  = 10'(H_ACTIVE - 1);
    localparam logic [9:0] H_FP_LAST   = 10'(H_ACTIVE + H_FP - 1);
    localparam logic [9:0] H_SYNC_LAST = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] H_LAST      = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_ACT_LAST  = 10'(V_ACTIVE - 1);
    localparam logic [9:0] V_FP_LAST   = 10'(V_ACTIVE + V_FP - 1);
    localparam logic [9:0] V_SYNC_LAST = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [9:0] V_LAST      = 10'(V_TOTAL - 1);
    localparam logic [3:0] DIV_LAST    = 4'(CLK_DIV - 1);

    typedef enum logic [1:0] {
        HS_ACT  = 2'd0,
        HS_FP   = 2'd1,
        HS_SYNC = 2'd2,
        HS_BP   = 2'd3
    } h_state_e;

    typedef enum logic [1:0] {
        VS_ACT  = 2'd0,
        VS_FP   = 2'd1,
        VS_SYNC = 2'd2,
        VS_BP   = 2'd3
    } v_state_e;

    logic       en_q, en_d;
    logic [3:0] div_q, div_d;
    logic [9:0] pix_x_q, pix_x_d;
    logic [9:0] pix_y_q, pix_y_d;
    logic [7:0] frame_count_q, frame_count_d;
    h_state_e   h_state_q, h_state_d;
    v_state_e   v_state_q, v_state_d;

    logic tick_c;
    logic line_end_c;
    logic frame_end_c;

    // Strobes decoded from registered state only.
    assign tick_c      = en_q && (div_q == DIV_LAST);
    assign line_end_c  = tick_c && (pix_x_q == H_LAST);
    assign frame_end_c = line_end_c && (pix_y_q == V_LAST);

    // Divider, pixel/line counters and completed-frame counter.
    always_comb begin
        en_d          = enable;
        div_d         = div_q;
        pix_x_d       = pix_x_q;
        pix_y_d       = pix_y_q;
        frame_count_d = frame_count_q;
        if (en_q) begin
            div_d = (div_q == DIV_LAST) ? 4'd0 : div_q + 4'd1;
        end
        if (tick_c) begin
            pix_x_d = (pix_x_q == H_LAST) ? 10'd0 : pix_x_q + 10'd1;
        end
        if (line_end_c) begin
            pix_y_d = (pix_y_q == V_LAST) ? 10'd0 : pix_y_q + 10'd1;
        end
        if (frame_end_c) begin
            frame_count_d = frame_count_q + 8'd1;
        end
    end

    // Horizontal phase FSM, stepped on pixel ticks.
    always_comb begin
        h_state_d = h_state_q;
        if (tick_c) begin
            case (h_state_q)
                HS_ACT:  if (pix_x_q == H_ACT_LAST)  h_state_d = HS_FP;
                HS_FP:   if (pix_x_q == H_FP_LAST)   h_state_d = HS_SYNC;
                HS_SYNC: if (pix_x_q == H_SYNC_LAST) h_state_d = HS_BP;
                HS_BP:   if (pix_x_q == H_LAST)      h_state_d = HS_ACT;
                default: h_state_d = HS_ACT;
            endcase
        end
    end

    // Vertical phase FSM, stepped only when a line wraps.
    always_comb begin
        v_state_d = v_state_q;
        if (line_end_c) begin
            case (v_state_q)
                VS_ACT:  if (pix_y_q == V_ACT_LAST)  v_state_d = VS_FP;
                VS_FP:   if (pix_y_q == V_FP_LAST)   v_state_d = VS_SYNC;
                VS_SYNC: if (pix_y_q == V_SYNC_LAST) v_state_d = VS_BP;
                VS_BP:   if (pix_y_q == V_LAST)      v_state_d = VS_ACT;
                default: v_state_d = VS_ACT;
            endcase
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            en_q          <= 1'b0;
            div_q         <= 4'd0;
            pix_x_q       <= 10'd0;
            pix_y_q       <= 10'd0;
            frame_count_q <= 8'd0;
            h_state_q     <= HS_ACT;
            v_state_q     <= VS_ACT;
        end else begin
            en_q          <= en_d;
            div_q         <= div_d;
            pix_x_q       <= pix_x_d;
            pix_y_q       <= pix_y_d;
            frame_count_q <= frame_count_d;
            h_state_q     <= h_state_d;
            v_state_q     <= v_state_d;
        end
    end

    assign pix_tick    = tick_c;
    assign pix_x       = pix_x_q;
    assign pix_y       = pix_y_q;
    assign hsync       = (h_state_q == HS_SYNC) ? SYNC_POL : ~SYNC_POL;
    assign vsync       = (v_state_q == VS_SYNC) ? SYNC_POL : ~SYNC_POL;
    assign active      = en_q && (h_state_q == HS_ACT) && (v_state_q == VS_ACT);
    assign line_end    = line_end_c;
    assign frame_end   = frame_end_c;
    assign frame_count = frame_count_q;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
`timescale 1ns/1ps
// Bench for vga_timing_ctrl. Three instances run side by side:
//   0: default 640x480 timing, CLK_DIV=1, active-low sync
//   1: shrunken 15x9 timing (frames are cheap), CLK_DIV=1, active-low sync
//   2: default 640x480 timing, CLK_DIV=4, active-high sync
// A cycle model pushes expected outputs at each posedge; a monitor pops and
// compares on the negedge. Directed sequences add hand-computed checks.
module tb_vga_timing_ctrl;

    localparam int N = 3;
    localparam int HA[N]  = '{640, 8, 640};
    localparam int HF[N]  = '{16, 2, 16};
    localparam int HS[N]  = '{96, 3, 96};
    localparam int HB[N]  = '{48, 2, 48};
    localparam int VA[N]  = '{480, 4, 480};
    localparam int VF[N]  = '{10, 1, 10};
    localparam int VS[N]  = '{2, 2, 2};
    localparam int VB[N]  = '{33, 2, 33};
    localparam int DIV[N] = '{1, 1, 4};
    localparam int POL[N] = '{0, 0, 1};

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0]       rst_n_i, en_i;
    logic [N-1:0]       tick_o, hs_o, vs_o, act_o, le_o, fe_o;
    logic [N-1:0][9:0]  x_o, y_o;
    logic [N-1:0][7:0]  fc_o;
    logic [N-1:0][1:0]  h_st, v_st;

    vga_timing_ctrl u0 (
        .clk(clk), .reset_n(rst_n_i[0]), .enable(en_i[0]), .pix_tick(tick_o[0]),
        .pix_x(x_o[0]), .pix_y(y_o[0]), .hsync(hs_o[0]), .vsync(vs_o[0]),
        .active(act_o[0]), .line_end(le_o[0]), .frame_end(fe_o[0]), .frame_count(fc_o[0])
    );

    vga_timing_ctrl #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(2),
        .CLK_DIV(1), .SYNC_POL(1'b0)
    ) u1 (
        .clk(clk), .reset_n(rst_n_i[1]), .enable(en_i[1]), .pix_tick(tick_o[1]),
        .pix_x(x_o[1]), .pix_y(y_o[1]), .hsync(hs_o[1]), .vsync(vs_o[1]),
        .active(act_o[1]), .line_end(le_o[1]), .frame_end(fe_o[1]), .frame_count(fc_o[1])
    );

    vga_timing_ctrl #(
        .CLK_DIV(4), .SYNC_POL(1'b1)
    ) u2 (
        .clk(clk), .reset_n(rst_n_i[2]), .enable(en_i[2]), .pix_tick(tick_o[2]),
        .pix_x(x_o[2]), .pix_y(y_o[2]), .hsync(hs_o[2]), .vsync(vs_o[2]),
        .active(act_o[2]), .line_end(le_o[2]), .frame_end(fe_o[2]), .frame_count(fc_o[2])
    );

    assign h_st[0] = u0.h_state_q;
    assign h_st[1] = u1.h_state_q;
    assign h_st[2] = u2.h_state_q;
    assign v_st[0] = u0.v_state_q;
    assign v_st[1] = u1.v_state_q;
    assign v_st[2] = u2.v_state_q;

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_errs   = 0;
    logic [33:0] exp_q[$];

    task automatic finish_run();
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errs++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
            if (n_errs >= 100) finish_run();
        end
    endtask

    task automatic check_vec(input string name, input logic [33:0] act, input logic [33:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
            if (n_errs >= 100) finish_run();
        end
    endtask

    // ---------------- reference model ----------------
    int m_en[N]  = '{0, 0, 0};
    int m_div[N] = '{0, 0, 0};
    int m_x[N]   = '{0, 0, 0};
    int m_y[N]   = '{0, 0, 0};
    int m_fc[N]  = '{0, 0, 0};

    function automatic int h_total(input int i);
        return HA[i] + HF[i] + HS[i] + HB[i];
    endfunction

    function automatic int v_total(input int i);
        return VA[i] + VF[i] + VS[i] + VB[i];
    endfunction

    // Phase index from a counter value: 0 active, 1 fp, 2 sync, 3 bp.
    function automatic int exp_phase(input int c, input int a, input int f, input int s);
        if (c < a) return 0;
        if (c < a + f) return 1;
        if (c < a + f + s) return 2;
        return 3;
    endfunction

    task automatic model_step(input int i);
        int tk, le, fe;
        if (!rst_n_i[i]) begin
            m_en[i] = 0; m_div[i] = 0; m_x[i] = 0; m_y[i] = 0; m_fc[i] = 0;
        end else begin
            tk = int'(m_en[i] != 0 && m_div[i] == DIV[i] - 1);
            le = int'(tk != 0 && m_x[i] == h_total(i) - 1);
            fe = int'(le != 0 && m_y[i] == v_total(i) - 1);
            if (fe != 0) m_fc[i] = (m_fc[i] + 1) % 256;
            if (tk != 0) m_x[i] = (m_x[i] == h_total(i) - 1) ? 0 : m_x[i] + 1;
            if (le != 0) m_y[i] = (m_y[i] == v_total(i) - 1) ? 0 : m_y[i] + 1;
            if (m_en[i] != 0) m_div[i] = (m_div[i] == DIV[i] - 1) ? 0 : m_div[i] + 1;
            m_en[i] = int'(en_i[i]);
        end
    endtask

    function automatic logic [33:0] model_out(input int i);
        logic tk, le, fe, hs, vs, act, p;
        p   = POL[i] != 0;
        tk  = m_en[i] != 0 && m_div[i] == DIV[i] - 1;
        le  = tk && m_x[i] == h_total(i) - 1;
        fe  = le && m_y[i] == v_total(i) - 1;
        hs  = (exp_phase(m_x[i], HA[i], HF[i], HS[i]) == 2) ? p : ~p;
        vs  = (exp_phase(m_y[i], VA[i], VF[i], VS[i]) == 2) ? p : ~p;
        act = m_en[i] != 0 && m_x[i] < HA[i] && m_y[i] < VA[i];
        return {tk, 10'(m_x[i]), 10'(m_y[i]), hs, vs, act, le, fe, 8'(m_fc[i])};
    endfunction

    // Model: advance on each posedge and queue the expected post-edge outputs.
    initial begin
        forever begin
            @(posedge clk);
            for (int i = 0; i < N; i++) begin
                model_step(i);
                exp_q.push_back(model_out(i));
            end
        end
    end

    // Monitor: pop expectations and compare, plus phase/counter agreement.
    initial begin
        logic [33:0] a_v;
        forever begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if (exp_q.size() == 0) begin
                    check($sformatf("inst%0d_sb_underflow", i), 0, 1);
                end else begin
                    a_v = {tick_o[i], x_o[i], y_o[i], hs_o[i], vs_o[i], act_o[i],
                           le_o[i], fe_o[i], fc_o[i]};
                    check_vec($sformatf("inst%0d_outputs", i), a_v, exp_q.pop_front());
                end
                check($sformatf("inst%0d_h_phase", i), int'(h_st[i]),
                      exp_phase(int'(x_o[i]), HA[i], HF[i], HS[i]));
                check($sformatf("inst%0d_v_phase", i), int'(v_st[i]),
                      exp_phase(int'(y_o[i]), VA[i], VF[i], VS[i]));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_xy(input int i, input int x, input int y, input int budget, input string name);
        int c = 0;
        while (!(int'(x_o[i]) == x && int'(y_o[i]) == y && tick_o[i]) && c < budget) begin
            @(negedge clk);
            c++;
        end
        check(name, int'(c < budget), 1);
    endtask

    // Default timing: one line of sync/active measurement, then a mid-line pause.
    task automatic seq0();
        int hsl = 0, first = -1, last = -1, acts = 0, le_cnt = 0, le_x = -1;
        int ticks = 0, hold = 0;
        bit paused = 0, seen_le = 0;
        @(negedge clk);
        check("d_first_x", int'(x_o[0]), 0);
        check("d_first_tick", int'(tick_o[0]), 1);
        for (int k = 0; k < 800; k++) begin
            if (!hs_o[0]) begin
                hsl++;
                if (first < 0) first = int'(x_o[0]);
                last = int'(x_o[0]);
            end
            if (act_o[0]) acts++;
            if (le_o[0]) begin le_cnt++; le_x = int'(x_o[0]); end
            @(negedge clk);
        end
        check("d_hsync_width", hsl, 96);
        check("d_hsync_first_x", first, 656);
        check("d_hsync_last_x", last, 751);
        check("d_active_per_line", acts, 640);
        check("d_line_end_count", le_cnt, 1);
        check("d_line_end_x", le_x, 799);
        check("d_line1_y", int'(y_o[0]), 1);
        check("d_line1_x", int'(x_o[0]), 0);
        // Line 1: pause at x=300 for 50 clks; the line must still take 800 ticks.
        for (int c = 0; c < 2000 && !seen_le; c++) begin
            if (tick_o[0]) ticks++;
            if (le_o[0]) begin
                seen_le = 1;
            end else if (!paused) begin
                if (tick_o[0] && int'(x_o[0]) == 300) begin
                    en_i[0] = 1'b0;
                    paused  = 1;
                end
            end else if (hold < 50) begin
                hold++;
                check("d_pause_x", int'(x_o[0]), 301);
                check("d_pause_active", int'(act_o[0]), 0);
                check("d_pause_tick", int'(tick_o[0]), 0);
                if (hold == 50) en_i[0] = 1'b1;
            end
            if (!seen_le) @(negedge clk);
        end
        check("d_pause_line_end_seen", int'(seen_le), 1);
        check("d_pause_line_ticks", ticks, 800);
        check("d_vsync_idle", int'(vs_o[0]), 1);
    endtask

    // Shrunken timing: frame strobes, frame counter, reset inside vsync, wrap.
    task automatic seq1();
        int c = 0, len = 0, acts = 0, hsl = 0, vsl = 0;
        while (!fe_o[1] && c < 400) begin @(negedge clk); c++; end
        check("s_first_frame_end", int'(c < 400), 1);
        check("s_fc_at_first_fe", int'(fc_o[1]), 0);
        do begin
            @(negedge clk);
            len++;
            if (act_o[1]) acts++;
            if (!hs_o[1]) hsl++;
            if (!vs_o[1]) vsl++;
        end while (!fe_o[1] && len < 400);
        check("s_frame_len", len, 135);
        check("s_active_per_frame", acts, 32);
        check("s_hsync_low_per_frame", hsl, 27);
        check("s_vsync_low_per_frame", vsl, 30);
        check("s_fc_at_second_fe", int'(fc_o[1]), 1);
        @(negedge clk);
        check("s_fc_after_two", int'(fc_o[1]), 2);
        wait_xy(1, 11, 5, 300, "s_reach_vsync");
        check("s_vsync_asserted", int'(vs_o[1]), 0);
        check("s_hsync_asserted", int'(hs_o[1]), 0);
        rst_n_i[1] = 1'b0;
        @(negedge clk);
        check("s_rst_x", int'(x_o[1]), 0);
        check("s_rst_y", int'(y_o[1]), 0);
        check("s_rst_hsync", int'(hs_o[1]), 1);
        check("s_rst_vsync", int'(vs_o[1]), 1);
        check("s_rst_fc", int'(fc_o[1]), 0);
        check("s_rst_active", int'(act_o[1]), 0);
        check("s_rst_tick", int'(tick_o[1]), 0);
        check("s_rst_h_state", int'(h_st[1]), 0);
        check("s_rst_v_state", int'(v_st[1]), 0);
        rst_n_i[1] = 1'b1;
        c = 0;
        while (!(fe_o[1] && fc_o[1] == 8'd255) && c < 40000) begin @(negedge clk); c++; end
        check("s_reach_fc_255", int'(c < 40000), 1);
        @(negedge clk);
        check("s_fc_wrap", int'(fc_o[1]), 0);
    endtask

    // Default timing with CLK_DIV=4 and active-high sync.
    task automatic seq2();
        int c = 0, len = 0, hsh = 0, ticks = 0, last_tick = 0, bad_gap = 0;
        while (!le_o[2] && c < 5000) begin @(negedge clk); c++; end
        check("v_first_line_end", int'(c < 5000), 1);
        do begin
            @(negedge clk);
            len++;
            if (hs_o[2]) hsh++;
            if (tick_o[2]) begin
                ticks++;
                if (len - last_tick != 4) bad_gap++;
                last_tick = len;
            end
        end while (!le_o[2] && len < 5000);
        check("v_line_end_spacing", len, 3200);
        check("v_hsync_width", hsh, 384);
        check("v_ticks_per_line", ticks, 800);
        check("v_tick_period_errors", bad_gap, 0);
        check("v_vsync_idle", int'(vs_o[2]), 0);
        check("v_line_end_y", int'(y_o[2]), 1);
        @(negedge clk);
        check("v_line_end_pulse", int'(le_o[2]), 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst_n_i = '0;
        en_i    = '1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < N; i++) begin
            check($sformatf("inst%0d_rst_x", i), int'(x_o[i]), 0);
            check($sformatf("inst%0d_rst_y", i), int'(y_o[i]), 0);
            check($sformatf("inst%0d_rst_hsync", i), int'(hs_o[i]), 1 - POL[i]);
            check($sformatf("inst%0d_rst_vsync", i), int'(vs_o[i]), 1 - POL[i]);
            check($sformatf("inst%0d_rst_active", i), int'(act_o[i]), 0);
            check($sformatf("inst%0d_rst_tick", i), int'(tick_o[i]), 0);
            check($sformatf("inst%0d_rst_line_end", i), int'(le_o[i]), 0);
            check($sformatf("inst%0d_rst_fc", i), int'(fc_o[i]), 0);
        end
        rst_n_i = '1;
        fork
            seq0();
            seq1();
            seq2();
        join
        repeat (2) @(negedge clk);
        #1;
        finish_run();
    end

endmodule
